nco_mixer_accum: RTL

NCO_MIXER_ACCUM -- requirements
Module: nco_mixer_accum

---
 rtl/nco_mixer_accum.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/nco_mixer_accum.sv
// nco_mixer_accum: multiplies ADC samples by an NCO sine and integrates acc_len products into one result.
// Optional macro MIXER_SAT_EN: saturating accumulator with sticky ovf; without it the sum wraps and ovf stays 0.
module nco_mixer_accum #(
    parameter int ADC_W = 14,
    parameter int NCO_W = 13,
    parameter int ACC_W = 44,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    input  logic [NCO_W-1:0] nco_sin,
    input  logic             nco_valid,
    input  logic [LEN_W-1:0] acc_len,
    input  logic             start,
    output logic             busy,
    output logic [ACC_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             ovf
);
    localparam int PW = ADC_W + NCO_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]              state_r;
    logic [1:0]              state_nxt_s;
    logic [LEN_W-1:0]        len_r;
    logic [LEN_W-1:0]        cnt_r;
    logic signed [PW-1:0]    prod_r;
    logic signed [PW-1:0]    mult_s;
    logic                    prod_vld_r;
    logic signed [ACC_W-1:0] acc_r;
    logic signed [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0]        res_data_r;
    logic                    sum_ovf_s;
    logic                    res_valid_r;
    logic                    busy_r;
    logic                    ovf_r;
    logic                    accept_s;
    logic                    last_s;
    logic                    launch_s;

`ifdef MIXER_SAT_EN
    localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;

    // Returns {overflow, sum}; the sum is clamped to the signed ACC_W range on overflow.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [PW-1:0] p);
        logic signed [SW-1:0] wide;
        logic [SW-ACC_W:0]    hi;
        logic                 hit;
        wide = SW'(a) + SW'(p);
        hi   = wide[SW-1:ACC_W-1];
        hit  = !((&hi) || !(|hi));
        if (!hit) begin
            acc_add = {1'b0, wide[ACC_W-1:0]};
        end else if (wide[SW-1]) begin
            acc_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            acc_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end
    endfunction
`else
    // Returns {overflow, sum}; modulo-2^ACC_W sum, overflow never reported.
    function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [PW-1:0] p);
        acc_add = {1'b0, a + ACC_W'(p)};
    endfunction
`endif

    // Datapath decode: multiplier, accumulator adder and pair acceptance.
    always_comb begin
        mult_s               = PW'($signed(adc_data)) * PW'($signed(nco_sin));
        {sum_ovf_s, sum_s}   = acc_add(acc_r, prod_r);
        accept_s             = (state_r == S_RUN) && adc_valid && nco_valid;
        last_s               = accept_s && (cnt_r == (len_r - LEN_W'(1)));
        launch_s             = (state_r == S_IDLE) && start && (acc_len != {LEN_W{1'b0}});
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (launch_s) state_nxt_s = S_RUN;
                else          state_nxt_s = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_nxt_s = S_FLUSH;
                else        state_nxt_s = S_RUN;
            end
            S_FLUSH: state_nxt_s = S_HOLD;
            S_HOLD: begin
                if (res_ready) state_nxt_s = S_IDLE;
                else           state_nxt_s = S_HOLD;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State, product pipeline, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            len_r       <= {LEN_W{1'b0}};
            cnt_r       <= {LEN_W{1'b0}};
            prod_r      <= {PW{1'b0}};
            prod_vld_r  <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            ovf_r       <= 1'b0;
            res_data_r  <= {ACC_W{1'b0}};
            res_valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != S_IDLE);
            if (launch_s) begin
                len_r      <= acc_len;
                cnt_r      <= {LEN_W{1'b0}};
                acc_r      <= {ACC_W{1'b0}};
                ovf_r      <= 1'b0;
                prod_vld_r <= 1'b0;
            end else begin
                // The product of the last pair is folded in during FLUSH.
                if (((state_r == S_RUN) || (state_r == S_FLUSH)) && prod_vld_r) begin
                    acc_r <= sum_s;
                    ovf_r <= ovf_r | sum_ovf_s;
                end
                if (accept_s) begin
                    prod_r <= mult_s;
                    cnt_r  <= cnt_r + LEN_W'(1);
                end
                prod_vld_r <= accept_s;
            end
            if (state_r == S_FLUSH) begin
                res_data_r  <= sum_s;
                res_valid_r <= 1'b1;
            end else if ((state_r == S_HOLD) && res_ready) begin
                res_valid_r <= 1'b0;
            end
        end
    end

    assign busy      = busy_r;
    assign res_data  = res_data_r;
    assign res_valid = res_valid_r;
    assign ovf       = ovf_r;

endmodule
